// File: rtl/tone_sequencer.sv
// Note scheduler: queues {freq, duration} notes in a FIFO and plays them in order,
// timing each note in prescaled ticks and inserting a silent gap after it.
module tone_sequencer #(
    parameter int FREQ_W    = 8,
    parameter int DUR_W     = 8,
    parameter int DEPTH     = 8,
    parameter int TICK_DIV  = 1000,
    parameter int GAP_TICKS = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [FREQ_W-1:0]          in_freq,
    input  logic [DUR_W-1:0]           in_dur,
    output logic                       in_ready,
    input  logic                       enable,
    input  logic                       flush,
    output logic [FREQ_W-1:0]          freq_out,
    output logic                       gate,
    output logic                       note_done,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int CW = (DUR_W > GW) ? DUR_W : GW;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t                   state_q, state_d;
    logic [FREQ_W+DUR_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]            level_q;
    logic [FREQ_W-1:0]        freq_q;
    logic [DUR_W-1:0]         last_q;
    logic [PW-1:0]            presc_q, presc_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     done_q, done_d;

    logic                     push, pop, empty, full, tick, clr;
    logic [FREQ_W-1:0]        head_freq;
    logic [DUR_W-1:0]         head_dur;

    assign empty     = (level_q == '0);
    assign full      = (level_q == LW'(DEPTH));
    assign in_ready  = !full && !flush;
    assign push      = in_valid && in_ready;
    assign head_freq = mem_q[rd_ptr_q][FREQ_W+DUR_W-1:DUR_W];
    assign head_dur  = mem_q[rd_ptr_q][DUR_W-1:0];
    assign tick      = (presc_q == PW'(TICK_DIV - 1));
    assign clr       = !reset_n || flush;

    assign freq_out  = freq_q;
    assign gate      = (state_q == S_PLAY) && enable && (freq_q != '0);
    assign note_done = done_q;
    assign busy      = (state_q != S_IDLE);
    assign level     = level_q;

    // Everything freezes while paused; a pop only ever accompanies entry into PLAY.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (enable) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_PLAY;
                        presc_d = '0;
                        cnt_d   = '0;
                    end
                end
                S_PLAY: begin
                    if (!tick) begin
                        presc_d = presc_q + 1'b1;
                    end else if (cnt_q != CW'(last_q)) begin
                        presc_d = '0;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        presc_d = '0;
                        cnt_d   = '0;
                        if (GAP_TICKS > 0) begin
                            state_d = S_GAP;
                        end else if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (!tick) begin
                        presc_d = presc_q + 1'b1;
                    end else if (int'(cnt_q) != GAP_TICKS - 1) begin
                        presc_d = '0;
                        cnt_d   = cnt_q + 1'b1;
                    end else begin
                        presc_d = '0;
                        cnt_d   = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = S_PLAY;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Flush keeps the last frequency; only reset clears it. Zero duration plays as one tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            freq_q <= '0;
            last_q <= '0;
        end else if (pop && !flush) begin
            freq_q <= head_freq;
            last_q <= (head_dur == '0) ? '0 : head_dur - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_freq, in_dur};
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: queued notes are checked for frequency,
// audible length and spacing as each note_done pulse arrives.
module tb_tone_sequencer;
    localparam int FW = 8;
    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int TD = 4;
    localparam int GT = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [FW-1:0] in_freq = '0;
    logic [DW-1:0] in_dur = '0;
    logic          in_ready;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic [FW-1:0] freq_out;
    logic          gate;
    logic          note_done;
    logic          busy;
    logic [3:0]    level;

    always #5 clk = ~clk;

    tone_sequencer #(
        .FREQ_W(FW), .DUR_W(DW), .DEPTH(DEPTH), .TICK_DIV(TD), .GAP_TICKS(GT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_freq(in_freq),
        .in_dur(in_dur), .in_ready(in_ready), .enable(enable), .flush(flush),
        .freq_out(freq_out), .gate(gate), .note_done(note_done), .busy(busy),
        .level(level)
    );

    typedef struct packed {
        logic [FW-1:0] f;
        logic [DW-1:0] d;
    } note_t;

    note_t exp_q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    gate_cnt = 0;
    int    since_done = 0;
    bit    chain_on = 1'b0;
    bit    have_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard side: each note_done retires the oldest accepted note.
    always @(negedge clk) begin
        if (!reset_n || flush) begin
            exp_q.delete();
            gate_cnt   = 0;
            since_done = 0;
            have_prev  = 1'b0;
        end else begin
            since_done++;
            if (gate) gate_cnt++;
            if (note_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    note_t e;
                    int    d;
                    e = exp_q.pop_front();
                    d = (e.d == 0) ? 1 : int'(e.d);
                    chk("note_freq", freq_out, e.f);
                    chk("note_gate_clks", gate_cnt, (e.f != 0) ? d * TD : 0);
                    if (chain_on && have_prev) chk("note_spacing", since_done, d * TD + GT * TD);
                    have_prev = 1'b1;
                end
                gate_cnt   = 0;
                since_done = 0;
            end
        end
    end

    task automatic push(input logic [FW-1:0] f, input logic [DW-1:0] d, input bit acc);
        in_freq  = f;
        in_dur   = d;
        in_valid = 1'b1;
        chk("in_ready_at_push", in_ready, acc);
        if (acc) exp_q.push_back({f, d});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_clks);
        bit ok = 1'b0;
        for (int k = 0; k < max_clks; k++) begin
            @(posedge clk);
            #1;
            if (!busy && level == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_freq", freq_out, 0);
        chk("rst_gate", gate, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", note_done, 0);
        reset_n = 1'b1;

        // Single note {20,3}
        enable = 1'b1;
        @(posedge clk);
        #1;
        push(8'd20, 8'd3, 1'b1);
        chk("e1_gate", gate, 0);
        chk("e1_level", level, 1);
        @(posedge clk);
        #1;
        chk("e2_gate", gate, 1);
        chk("e2_freq", freq_out, 20);
        chk("e2_level", level, 0);
        begin
            int bc = 1;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (busy) bc++;
                else break;
            end
            chk("busy_clks", bc, 16);
        end
        chk("sb_empty_t2", exp_q.size(), 0);

        // Fill while paused, ninth note dropped, then play back
        enable = 1'b0;
        for (int i = 0; i < 9; i++) push(8'(40 + i), 8'(1 + (i % 3)), i < 8);
        chk("full_level", level, 8);
        chk("full_in_ready", in_ready, 0);
        have_prev = 1'b0;
        chain_on  = 1'b1;
        enable    = 1'b1;
        wait_idle("t3_idle_timeout", 300);
        chain_on = 1'b0;
        chk("sb_empty_t3", exp_q.size(), 0);

        // Rest note, short note, zero-length note
        push(8'd0, 8'd2, 1'b1);
        push(8'd50, 8'd1, 1'b1);
        push(8'd33, 8'd0, 1'b1);
        wait_idle("t4_idle_timeout", 100);
        chk("freq_hold", freq_out, 33);
        chk("idle_gate", gate, 0);
        chk("sb_empty_t4", exp_q.size(), 0);

        // Pause for 5 clks mid-note
        push(8'd20, 8'd3, 1'b1);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (k >= 6 && k <= 10) chk("pause_gate", gate, 0);
                if (note_done) begin
                    chk("done_delay", k, 18);
                    seen = 1'b1;
                    break;
                end
                if (k == 5)  #1 enable = 1'b0;
                if (k == 10) #1 enable = 1'b1;
            end
            chk("pause_done_seen", seen, 1);
        end
        @(posedge clk);
        #1;
        wait_idle("t5_idle_timeout", 40);

        // Flush while playing with three notes queued
        push(8'd60, 8'd4, 1'b1);
        push(8'd61, 8'd1, 1'b1);
        push(8'd62, 8'd1, 1'b1);
        push(8'd63, 8'd1, 1'b1);
        chk("pre_flush_level", level, 3);
        chk("pre_flush_busy", busy, 1);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_gate", gate, 0);
        chk("flush_busy", busy, 0);
        chk("flush_freq", freq_out, 60);
        begin
            int nd = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (note_done) nd++;
            end
            chk("flush_no_done", nd, 0);
        end

        // Reset mid-note clears freq_out as well
        @(posedge clk);
        #1;
        push(8'd70, 8'd2, 1'b1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        chk("midrst_freq", freq_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_gate", gate, 0);
        chk("midrst_level", level, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
